// File: rtl/bit_block_generator.sv
// rtl/bit_block_generator.sv - serial generator of a 32-bit word holding blocks of consecutive 1s
// One bit per clock, LSB first; reports the finished word with a one-cycle strobe and its block count.
module bit_block_generator #(
  parameter int FF_DLY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [4:0]  start_ofs,
  input  logic [4:0]  blk_num,
  input  logic [4:0]  blk_len,
  input  logic [4:0]  gap_len,
  output logic        busy,
  output logic [31:0] data,
  output logic        data_enb,
  output logic [4:0]  blk_made
);

  typedef enum logic [2:0] {IDLE, OFFS, ONES, GAP, FILL} state_t;

  state_t      state, state_nxt;
  logic [4:0]  bit_idx, bit_idx_nxt;
  logic [4:0]  seg_cnt, seg_cnt_nxt;
  logic [4:0]  blocks_left, blocks_left_nxt;
  logic [4:0]  made, made_nxt;
  logic [4:0]  ofs_q, ofs_nxt;
  logic [4:0]  len_q, len_nxt;
  logic [4:0]  gap_q, gap_nxt;
  logic [31:0] shreg, shreg_nxt;
  logic [31:0] data_nxt;
  logic        enb_nxt;
  logic [4:0]  blk_made_nxt;
  logic        bit_val;
  logic        first_bit;

  logic ff_dly_unused;
  assign ff_dly_unused = (FF_DLY != 0);

  assign busy      = (state != IDLE);
  assign bit_val   = (state == ONES);
  assign first_bit = (state == ONES) && (seg_cnt == 5'd0);

  always_comb begin
    state_nxt       = state;
    bit_idx_nxt     = bit_idx;
    seg_cnt_nxt     = seg_cnt;
    blocks_left_nxt = blocks_left;
    made_nxt        = made;
    ofs_nxt         = ofs_q;
    len_nxt         = len_q;
    gap_nxt         = gap_q;
    shreg_nxt       = shreg;
    data_nxt        = data;
    blk_made_nxt    = blk_made;
    enb_nxt         = 1'b0;

    if (state == IDLE) begin
      if (req) begin
        ofs_nxt         = start_ofs;
        len_nxt         = blk_len;
        gap_nxt         = (gap_len == 5'd0) ? 5'd1 : gap_len;
        blocks_left_nxt = blk_num;
        made_nxt        = 5'd0;
        bit_idx_nxt     = 5'd0;
        seg_cnt_nxt     = 5'd0;
        shreg_nxt       = 32'd0;
        if (start_ofs != 5'd0)
          state_nxt = OFFS;
        else if (blk_num != 5'd0 && blk_len != 5'd0)
          state_nxt = ONES;
        else
          state_nxt = FILL;
      end
    end else begin
      shreg_nxt = {bit_val, shreg[31:1]};
      if (bit_idx == 5'd31) begin
        // A block whose first bit is bit 31 still counts.
        data_nxt     = shreg_nxt;
        blk_made_nxt = made + {4'd0, first_bit};
        enb_nxt      = 1'b1;
        state_nxt    = IDLE;
      end else begin
        bit_idx_nxt = bit_idx + 5'd1;
        seg_cnt_nxt = seg_cnt + 5'd1;
        case (state)
          OFFS: begin
            if (seg_cnt == ofs_q - 5'd1) begin
              seg_cnt_nxt = 5'd0;
              state_nxt   = (blocks_left != 5'd0 && len_q != 5'd0) ? ONES : FILL;
            end
          end
          ONES: begin
            if (first_bit)
              made_nxt = made + 5'd1;
            if (seg_cnt == len_q - 5'd1) begin
              seg_cnt_nxt     = 5'd0;
              blocks_left_nxt = blocks_left - 5'd1;
              state_nxt       = (blocks_left > 5'd1) ? GAP : FILL;
            end
          end
          GAP: begin
            if (seg_cnt == gap_q - 5'd1) begin
              seg_cnt_nxt = 5'd0;
              state_nxt   = ONES;
            end
          end
          default: seg_cnt_nxt = seg_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_idx     <= 5'd0;
      seg_cnt     <= 5'd0;
      blocks_left <= 5'd0;
      made        <= 5'd0;
      ofs_q       <= 5'd0;
      len_q       <= 5'd0;
      gap_q       <= 5'd0;
      shreg       <= 32'd0;
      data        <= 32'd0;
      data_enb    <= 1'b0;
      blk_made    <= 5'd0;
    end else begin
      state       <= state_nxt;
      bit_idx     <= bit_idx_nxt;
      seg_cnt     <= seg_cnt_nxt;
      blocks_left <= blocks_left_nxt;
      made        <= made_nxt;
      ofs_q       <= ofs_nxt;
      len_q       <= len_nxt;
      gap_q       <= gap_nxt;
      shreg       <= shreg_nxt;
      data        <= data_nxt;
      data_enb    <= enb_nxt;
      blk_made    <= blk_made_nxt;
    end
  end

endmodule
